// File: rtl/icmp_pkg.sv
// icmp_pkg: shared ICMP constants, FSM encoding and payload word selection for the tx scheduler
package icmp_pkg;

    localparam logic [7:0] ECHO_REPLY    = 8'd0;
    localparam logic [7:0] DEST_UNREACH  = 8'd3;
    localparam logic [7:0] TIME_EXCEEDED = 8'd11;

    localparam int WORD_W         = 32;
    localparam int PAYLOAD_WORDS  = 3;
    localparam int OUT_WORDS_DEF  = 5;
    localparam int OUT_OFFSET_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_GRST,
        S_LOAD,
        S_WAIT,
        S_EMIT
    } state_t;

    // word0 is the most significant word; anything past word1 returns word2
    function automatic logic [WORD_W-1:0] payload_word(input logic [PAYLOAD_WORDS*WORD_W-1:0] p,
                                                       input logic [4:0] w);
        return (w == 5'd0) ? p[95:64] : (w == 5'd1) ? p[63:32] : p[31:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first set request at or above ptr (wrapping), as index and one-hot
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  idx,
    output logic [NREQ-1:0] onehot
);

    localparam int SW = IDW + 1;

    logic [NREQ-1:0] rot;
    logic [SW-1:0]   sum;

    always_comb begin
        rot = NREQ'({req, req} >> ptr);
        sum = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, ptr} + SW'(k);
        idx    = (sum >= SW'(NREQ)) ? IDW'(sum - SW'(NREQ)) : sum[IDW-1:0];
        any    = |req;
        onehot = any ? (NREQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/icmp_tx_scheduler.sv
// icmp_tx_scheduler: round-robin sharing of one ICMP generator, sequencing its load and framing its output
module icmp_tx_scheduler
    import icmp_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int IDW        = 3,
    parameter int OUT_OFFSET = 8,
    parameter int OUT_WORDS  = 5
) (
    input  logic                clock,
    input  logic                hardreset_n,
    input  logic [NREQ-1:0]     req,
    output logic [NREQ-1:0]     gnt,
    input  logic [8*NREQ-1:0]   req_type,
    input  logic [8*NREQ-1:0]   req_code,
    input  logic [32*NREQ-1:0]  req_typedata,
    input  logic [96*NREQ-1:0]  req_payload,
    output logic                gen_hardreset,
    output logic [7:0]          gen_type,
    output logic [7:0]          gen_code,
    output logic [31:0]         gen_typedata,
    output logic [31:0]         gen_inputdata,
    input  logic [31:0]         gen_message,
    output logic [31:0]         out_data,
    output logic                out_valid,
    output logic                out_sop,
    output logic                out_eop,
    output logic [IDW-1:0]      out_src,
    output logic                busy,
    output logic [15:0]         frames_sent
);

    localparam int LAST = OUT_OFFSET + OUT_WORDS - 1;

    state_t          state, nstate;
    logic [IDW-1:0]  src, rr_ptr, arb_idx;
    logic [NREQ-1:0] sel_oh, arb_oh;
    logic            arb_any, hold, emit;
    logic [4:0]      cnt;
    logic [7:0]      lat_type, lat_code, sel_type, sel_code;
    logic [31:0]     lat_td, sel_td;
    logic [95:0]     lat_pl, sel_pl;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req),
        .ptr    (rr_ptr),
        .any    (arb_any),
        .idx    (arb_idx),
        .onehot (arb_oh)
    );

    always_comb begin
        sel_type = '0;
        sel_code = '0;
        sel_td   = '0;
        sel_pl   = '0;
        for (int i = 0; i < NREQ; i++)
            if (src == IDW'(i)) begin
                sel_type = req_type[8*i +: 8];
                sel_code = req_code[8*i +: 8];
                sel_td   = req_typedata[32*i +: 32];
                sel_pl   = req_payload[96*i +: 96];
            end
    end

    always_ff @(posedge clock or negedge hardreset_n) begin
        if (!hardreset_n) begin
            state       <= S_IDLE;
            src         <= '0;
            sel_oh      <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
            lat_type    <= '0;
            lat_code    <= '0;
            lat_td      <= '0;
            lat_pl      <= '0;
            frames_sent <= '0;
        end else begin
            state <= nstate;
            cnt   <= (state inside {S_LOAD, S_WAIT, S_EMIT}) ? cnt + 5'd1 : 5'd0;
            if (state == S_IDLE && arb_any) begin
                src    <= arb_idx;
                sel_oh <= arb_oh;
            end
            if (state == S_GRANT) begin
                lat_type <= sel_type;
                lat_code <= sel_code;
                lat_td   <= sel_td;
                lat_pl   <= sel_pl;
                rr_ptr   <= (src == IDW'(NREQ - 1)) ? '0 : src + 1'b1;
            end
            if (out_eop) frames_sent <= frames_sent + 16'd1;
        end
    end

    // cnt counts cycles since the first payload cycle, so LOAD/WAIT/EMIT boundaries are fixed offsets
    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:  nstate = arb_any ? S_GRANT : S_IDLE;
            S_GRANT: nstate = S_GRST;
            S_GRST:  nstate = S_LOAD;
            S_LOAD:  nstate = (cnt == 5'(PAYLOAD_WORDS - 1)) ? S_WAIT : S_LOAD;
            S_WAIT:  nstate = (cnt == 5'(OUT_OFFSET - 1)) ? S_EMIT : S_WAIT;
            S_EMIT:  nstate = (cnt == 5'(LAST)) ? S_IDLE : S_EMIT;
            default: nstate = S_IDLE;
        endcase
    end

    always_comb begin
        hold          = state inside {S_GRST, S_LOAD, S_WAIT, S_EMIT};
        emit          = state == S_EMIT;
        gnt           = (state == S_GRANT) ? sel_oh : '0;
        busy          = state != S_IDLE;
        gen_hardreset = !(state inside {S_LOAD, S_WAIT, S_EMIT});
        gen_type      = hold ? lat_type : '0;
        gen_code      = hold ? lat_code : '0;
        gen_typedata  = hold ? lat_td : '0;
        gen_inputdata = gen_hardreset ? '0 : payload_word(lat_pl, cnt);
        out_valid     = emit;
        out_data      = emit ? gen_message : '0;
        out_sop       = emit && cnt == 5'(OUT_OFFSET);
        out_eop       = emit && cnt == 5'(LAST);
        out_src       = emit ? src : '0;
    end

endmodule
